zircon_segled_avalon_master: RTL and testbench

//  Avalon-MM write master driving the six-digit segment-display register slave (offsets 0..5, data[3:0]).
//  - Accepts one display update (6 hex nibbles plus a per-digit write mask) over a valid/ready handshake.
//  - Issues one Avalon write per masked digit, honouring avm_waitrequest.
//  - Pulses upd_done when the last write completes.
//  - Sits between user logic (counter, clock, UART command decoder) and the Qsys fabric.

---
 rtl/zircon_segled_avalon_master_pkg.sv | 17 +
 rtl/zircon_segled_avalon_master_if.sv | 34 +++
 rtl/zircon_segled_avalon_master_next_digit.sv | 38 +++
 rtl/zircon_segled_avalon_master.sv | 128 ++++++++++++
 tb/tb_zircon_segled_avalon_master.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/zircon_segled_avalon_master_pkg.sv
// Shared definitions for the segment-display Avalon write master.
//   SEG_DIGITS  : number of display digits / slave registers
//   SEG_ADDR_W  : width of the Avalon word address
//   SEG_BLANK   : nibble value that shows a blank digit on the display
//   seg_state_t : master FSM state encoding (ST_IDLE, ST_WRITE)
package zircon_segled_avalon_master_pkg;

  localparam int SEG_DIGITS = 6;
  localparam int SEG_ADDR_W = 3;
  localparam logic [3:0] SEG_BLANK = 4'hF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } seg_state_t;

endpackage

// File: rtl/zircon_segled_avalon_master_if.sv
// Bundle of the update handshake and the Avalon-MM write channel.
//   upd_valid/upd_ready/upd_data/upd_mask/upd_done : user-side update request
//   avm_address/avm_write/avm_writedata/avm_waitrequest : Avalon-MM write master
// Modports:
//   master : the write master's view (drives ready/done and the Avalon request)
//   slave  : the surrounding logic's view (drives the request and waitrequest)
interface zircon_segled_avalon_master_if
  import zircon_segled_avalon_master_pkg::*;
#(
  parameter int DIGITS = SEG_DIGITS,
  parameter int ADDR_W = SEG_ADDR_W
) ();

  logic                  upd_valid;
  logic                  upd_ready;
  logic [4*DIGITS-1:0]   upd_data;
  logic [DIGITS-1:0]     upd_mask;
  logic                  upd_done;
  logic [ADDR_W-1:0]     avm_address;
  logic                  avm_write;
  logic [31:0]           avm_writedata;
  logic                  avm_waitrequest;

  modport master (
    input  upd_valid, upd_data, upd_mask, avm_waitrequest,
    output upd_ready, upd_done, avm_address, avm_write, avm_writedata
  );

  modport slave (
    output upd_valid, upd_data, upd_mask, avm_waitrequest,
    input  upd_ready, upd_done, avm_address, avm_write, avm_writedata
  );

endinterface

// File: rtl/zircon_segled_avalon_master_next_digit.sv
// Combinational search for the next digit to write.
//   mask : per-digit write mask
//   cur  : current digit index, signed; -1 searches from digit 0
//   nxt  : lowest set mask bit strictly above cur
//   none : no set mask bit lies above cur (nxt is 0 then)
module zircon_segled_avalon_master_next_digit
  import zircon_segled_avalon_master_pkg::*;
#(
  parameter  int DIGITS = SEG_DIGITS,
  localparam int IDX_W  = $clog2(DIGITS)
) (
  input  logic [DIGITS-1:0]       mask,
  input  logic signed [IDX_W:0]   cur,
  output logic [IDX_W-1:0]        nxt,
  output logic                    none
);

  logic [DIGITS-1:0] above;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_above
      assign above[gi] = mask[gi] && ($signed((IDX_W+1)'(gi)) > cur);
    end
  endgenerate

  // Scan downwards so the lowest qualifying index is the one that sticks.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (above[i]) begin
        nxt  = IDX_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/zircon_segled_avalon_master.sv
// Avalon-MM write master for the six-digit segment-display register slave.
// Takes one update (a nibble per digit plus a write mask) over valid/ready and
// issues one Avalon write per masked digit in ascending order, honouring
// waitrequest; upd_done pulses for one cycle when the last write has completed.
// Ports:
//   csi_clk     : system clock
//   rsi_reset_n : asynchronous active-low reset
//   bus         : update handshake + Avalon write channel (master modport)
module zircon_segled_avalon_master
  import zircon_segled_avalon_master_pkg::*;
#(
  parameter int DIGITS    = SEG_DIGITS,
  parameter int ADDR_W    = SEG_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic                            csi_clk,
  input  logic                            rsi_reset_n,
  zircon_segled_avalon_master_if.master   bus
);

  localparam int IDX_W = $clog2(DIGITS);

  seg_state_t            state_reg;
  logic [DIGITS-1:0]     mask_reg;
  logic [4*DIGITS-1:0]   data_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic                  ready_reg;
  logic                  done_reg;
  logic                  write_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [31:0]           wdata_reg;

  logic [3:0]            in_nib  [DIGITS];
  logic [3:0]            cap_nib [DIGITS];
  logic [IDX_W-1:0]      first_idx;
  logic                  first_none;
  logic [IDX_W-1:0]      next_idx;
  logic                  next_none;
  logic                  accept;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign in_nib[gi]  = bus.upd_data[4*gi +: 4];
      assign cap_nib[gi] = data_reg[4*gi +: 4];
    end
  endgenerate

  // First digit comes straight from the incoming mask so the first write can
  // be presented in the cycle right after the accept.
  zircon_segled_avalon_master_next_digit #(.DIGITS(DIGITS)) u_first (
    .mask (bus.upd_mask),
    .cur  ({(IDX_W+1){1'b1}}),
    .nxt  (first_idx),
    .none (first_none)
  );

  zircon_segled_avalon_master_next_digit #(.DIGITS(DIGITS)) u_next (
    .mask (mask_reg),
    .cur  ({1'b0, idx_reg}),
    .nxt  (next_idx),
    .none (next_none)
  );

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] k);
    return ADDR_W'(BASE_ADDR + int'(k));
  endfunction

  assign accept = bus.upd_valid && ready_reg;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_reg <= ST_IDLE;
      mask_reg  <= '0;
      data_reg  <= {DIGITS{SEG_BLANK}};
      idx_reg   <= '0;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ready_reg <= 1'b1;
          if (accept) begin
            data_reg <= bus.upd_data;
            mask_reg <= bus.upd_mask;
            if (first_none) begin
              // Empty mask: nothing to write, report completion at once.
              done_reg <= 1'b1;
            end else begin
              state_reg <= ST_WRITE;
              ready_reg <= 1'b0;
              write_reg <= 1'b1;
              idx_reg   <= first_idx;
              addr_reg  <= addr_of(first_idx);
              wdata_reg <= {28'b0, in_nib[first_idx]};
            end
          end
        end
        ST_WRITE: begin
          // While the slave stalls, every request register simply holds.
          if (!bus.avm_waitrequest) begin
            if (!next_none) begin
              idx_reg   <= next_idx;
              addr_reg  <= addr_of(next_idx);
              wdata_reg <= {28'b0, cap_nib[next_idx]};
            end else begin
              state_reg <= ST_IDLE;
              write_reg <= 1'b0;
              done_reg  <= 1'b1;
              ready_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.upd_ready     = ready_reg;
  assign bus.upd_done      = done_reg;
  assign bus.avm_write     = write_reg;
  assign bus.avm_address   = addr_reg;
  assign bus.avm_writedata = wdata_reg;

endmodule

// File: tb/tb_zircon_segled_avalon_master.sv
// Self-checking bench for zircon_segled_avalon_master: reset behaviour, a
// table of update vectors (full mask, stalled write, sparse mask, empty mask),
// reset during a stalled burst, and back-to-back updates with valid held high.
module tb_zircon_segled_avalon_master;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   pass_cnt;

  zircon_segled_avalon_master_if #(.DIGITS(6), .ADDR_W(3)) bus ();

  zircon_segled_avalon_master #(.DIGITS(6), .ADDR_W(3), .BASE_ADDR(0)) dut (
    .csi_clk     (clk),
    .rsi_reset_n (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0]      data;
    logic [5:0]       mask;
    int               stall_addr;
    int               stall_n;
    int               exp_n;
    logic [5:0][2:0]  exp_addr;
    logic [5:0][3:0]  exp_nib;
    int               exp_lat;
  } vec_t;

  vec_t vecs [5];

  // Observed Avalon writes (completed transfers) and upd_done cycles.
  int   w_addr [$];
  int   w_data [$];
  int   w_cyc  [$];
  int   d_cyc  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present an update just after a rising edge; it is accepted on the next edge.
  task automatic start(input logic [23:0] data, input logic [5:0] mask, input bit drop);
    chk("ready_before_accept", {31'b0, bus.upd_ready}, 32'd1);
    bus.upd_valid = 1'b1;
    bus.upd_data  = data;
    bus.upd_mask  = mask;
    @(posedge clk); #1;
    if (drop) begin
      bus.upd_valid = 1'b0;
      bus.upd_data  = 24'hFFFFFF;
      bus.upd_mask  = 6'h3F;
    end
  endtask

  // Cycle-by-cycle monitor; cycle 1 is the cycle right after the accept edge.
  task automatic observe(input int max_cyc, input int stall_addr, input int stall_n,
                         input bit drop_on_done, input int done_target);
    int   stall_left;
    bit   stalled;
    int   held_addr;
    int   held_data;
    stall_left = stall_n;
    stalled    = 1'b0;
    held_addr  = 0;
    held_data  = 0;
    w_addr.delete(); w_data.delete(); w_cyc.delete(); d_cyc.delete();
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (stalled) begin
        chk("stall_write_held", {31'b0, bus.avm_write}, 32'd1);
        chk("stall_addr_held", 32'(bus.avm_address), 32'(held_addr));
        chk("stall_data_held", bus.avm_writedata, 32'(held_data));
      end
      bus.avm_waitrequest = 1'b0;
      stalled = 1'b0;
      if (bus.avm_write) begin
        if (int'(bus.avm_address) == stall_addr && stall_left > 0) begin
          bus.avm_waitrequest = 1'b1;
          stall_left--;
          stalled   = 1'b1;
          held_addr = int'(bus.avm_address);
          held_data = int'(bus.avm_writedata);
        end else begin
          w_addr.push_back(int'(bus.avm_address));
          w_data.push_back(int'(bus.avm_writedata));
          w_cyc.push_back(cyc);
        end
      end
      if (bus.upd_done) begin
        d_cyc.push_back(cyc);
        if (d_cyc.size() == done_target) begin
          if (drop_on_done) bus.upd_valid = 1'b0;
          break;
        end
      end
      @(posedge clk); #1;
    end
    if (d_cyc.size() != done_target)
      chk("done_timeout", 32'(d_cyc.size()), 32'(done_target));
  endtask

  initial begin
    int n;
    int wr_cnt;
    int done_cnt;
    total_cnt = 0;
    pass_cnt  = 0;

    // vec 0: all six digits, no stalls
    vecs[0].data = 24'h123456; vecs[0].mask = 6'h3F;
    vecs[0].stall_addr = -1; vecs[0].stall_n = 0; vecs[0].exp_n = 6;
    vecs[0].exp_addr = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    vecs[0].exp_nib  = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    vecs[0].exp_lat = 7;
    // vec 1: same, slave stalls address 2 for three cycles
    vecs[1] = vecs[0];
    vecs[1].stall_addr = 2; vecs[1].stall_n = 3; vecs[1].exp_lat = 10;
    // vec 2: sparse mask 100101
    vecs[2].data = 24'hABCDEF; vecs[2].mask = 6'b100101;
    vecs[2].stall_addr = -1; vecs[2].stall_n = 0; vecs[2].exp_n = 3;
    vecs[2].exp_addr = {3'd0, 3'd0, 3'd0, 3'd5, 3'd2, 3'd0};
    vecs[2].exp_nib  = {4'h0, 4'h0, 4'h0, 4'hA, 4'hD, 4'hF};
    vecs[2].exp_lat = 4;
    // vec 3: empty mask
    vecs[3].data = 24'h777777; vecs[3].mask = 6'b000000;
    vecs[3].stall_addr = -1; vecs[3].stall_n = 0; vecs[3].exp_n = 0;
    vecs[3].exp_addr = '0; vecs[3].exp_nib = '0; vecs[3].exp_lat = 1;
    // vec 4: digits 1 and 4, one stall cycle on the last write
    vecs[4].data = 24'h987654; vecs[4].mask = 6'b010010;
    vecs[4].stall_addr = 4; vecs[4].stall_n = 1; vecs[4].exp_n = 2;
    vecs[4].exp_addr = {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd1};
    vecs[4].exp_nib  = {4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h5};
    vecs[4].exp_lat = 4;

    // Reset held five cycles
    rst_n = 1'b0;
    bus.upd_valid = 1'b0; bus.upd_data = '0; bus.upd_mask = '0;
    bus.avm_waitrequest = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, bus.upd_ready}, 32'd0);
    chk("rst_done", {31'b0, bus.upd_done}, 32'd0);
    chk("rst_write", {31'b0, bus.avm_write}, 32'd0);
    chk("rst_addr", 32'(bus.avm_address), 32'd0);
    chk("rst_wdata", bus.avm_writedata, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", {31'b0, bus.upd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_release", {31'b0, bus.upd_ready}, 32'd1);

    // Table-driven updates
    for (int v = 0; v < 5; v++) begin
      start(vecs[v].data, vecs[v].mask, 1'b1);
      observe(40, vecs[v].stall_addr, vecs[v].stall_n, 1'b0, 1);
      chk($sformatf("v%0d_write_count", v), 32'(w_addr.size()), 32'(vecs[v].exp_n));
      n = (w_addr.size() < vecs[v].exp_n) ? w_addr.size() : vecs[v].exp_n;
      for (int i = 0; i < n; i++) begin
        chk($sformatf("v%0d_w%0d_addr", v, i), 32'(w_addr[i]), 32'(vecs[v].exp_addr[i]));
        chk($sformatf("v%0d_w%0d_data", v, i), 32'(w_data[i]), {28'b0, vecs[v].exp_nib[i]});
      end
      if (d_cyc.size() > 0)
        chk($sformatf("v%0d_done_latency", v), 32'(d_cyc[0]), 32'(vecs[v].exp_lat));
      $display("vec %0d: data=%h mask=%b writes=%0d done_cycle=%0d",
               v, vecs[v].data, vecs[v].mask, w_addr.size(),
               (d_cyc.size() > 0) ? d_cyc[0] : -1);
    end

    // Reset while the address-3 write is stalled
    start(24'h123456, 6'h3F, 1'b1);
    wr_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.avm_write && bus.avm_address == 3'd3) break;
      if (bus.avm_write) wr_cnt++;
      @(posedge clk); #1;
    end
    chk("mid_reset_addr3_reached", {31'b0, bus.avm_write}, 32'd1);
    bus.avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_reset_stalled_addr", 32'(bus.avm_address), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_write_drop", {31'b0, bus.avm_write}, 32'd0);
    chk("mid_reset_ready", {31'b0, bus.upd_ready}, 32'd0);
    chk("mid_reset_prior_writes", 32'(wr_cnt), 32'd3);
    @(posedge clk); @(posedge clk); #1;
    bus.avm_waitrequest = 1'b0;
    rst_n = 1'b1;
    wr_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.avm_write) wr_cnt++;
      if (bus.upd_done) done_cnt++;
    end
    chk("post_reset_writes", 32'(wr_cnt), 32'd0);
    chk("post_reset_done", 32'(done_cnt), 32'd0);
    chk("post_reset_ready", {31'b0, bus.upd_ready}, 32'd1);
    $display("mid-burst reset: writes_after=%0d dones_after=%0d", wr_cnt, done_cnt);

    // Valid held high across two payloads; payload changes mid-burst
    start(24'h654321, 6'b000011, 1'b0);
    bus.upd_data = 24'hFEDCBA;
    bus.upd_mask = 6'b110000;
    observe(30, -1, 0, 1'b1, 2);
    chk("b2b_write_count", 32'(w_addr.size()), 32'd4);
    if (w_addr.size() == 4) begin
      chk("b2b_w0_addr", 32'(w_addr[0]), 32'd0); chk("b2b_w0_data", 32'(w_data[0]), 32'h1);
      chk("b2b_w1_addr", 32'(w_addr[1]), 32'd1); chk("b2b_w1_data", 32'(w_data[1]), 32'h2);
      chk("b2b_w2_addr", 32'(w_addr[2]), 32'd4); chk("b2b_w2_data", 32'(w_data[2]), 32'hE);
      chk("b2b_w3_addr", 32'(w_addr[3]), 32'd5); chk("b2b_w3_data", 32'(w_data[3]), 32'hF);
      chk("b2b_w0_cycle", 32'(w_cyc[0]), 32'd1);
      chk("b2b_w2_cycle", 32'(w_cyc[2]), 32'd4);
      chk("b2b_w3_cycle", 32'(w_cyc[3]), 32'd5);
    end
    if (d_cyc.size() == 2) begin
      chk("b2b_done0_cycle", 32'(d_cyc[0]), 32'd3);
      chk("b2b_done1_cycle", 32'(d_cyc[1]), 32'd6);
    end
    $display("back-to-back: writes=%0d dones=%0d", w_addr.size(), d_cyc.size());
    wr_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.avm_write) wr_cnt++;
    end
    chk("b2b_no_extra_writes", 32'(wr_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
